// File: rtl/muldiv_ctrl_if.sv
// Start/operand handshake and HI/LO result bus between control_unit and the
// iterative multiply/divide sequencer.
interface muldiv_ctrl_if #(parameter int WIDTH = 32);
   logic             start;
   logic             op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic             div_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             hi_write;
   logic             lo_write;

   modport master (output start, op, a, b,
                   input  busy, done, div_zero, hi, lo, hi_write, lo_write);
   modport slave  (input  start, op, a, b,
                   output busy, done, div_zero, hi, lo, hi_write, lo_write);
endinterface

// File: rtl/muldiv_ctrl.sv
// Iterative signed MULT/DIV sequencer: one shift-add or restoring shift-subtract
// step per cycle on operand magnitudes, sign fix-up on the way into HI/LO.
module muldiv_ctrl #(
   parameter int WIDTH = 32
) (
   input logic          clock,
   input logic          reset,
   muldiv_ctrl_if.slave bus
);
   localparam int            CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST    = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FINISH = 2'd2} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q;
   logic               op_q, neg_q, neg_a_q;
   logic [WIDTH-1:0]   opnd_q, acc_q, quo_q;
   logic               busy_q, busy_d, done_q, done_d, dz_q, dz_d;
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

   logic [WIDTH-1:0]   mag_a_s, mag_b_s, acc_nx_s, quo_nx_s, dif_s;
   logic [WIDTH:0]     sum_s, shf_s;
   logic [2*WIDTH-1:0] prod_s, prod_fix_s;
   logic               idle_start_s, reject_s, accept_s;

   assign mag_a_s      = bus.a[WIDTH-1] ? -bus.a : bus.a;
   assign mag_b_s      = bus.b[WIDTH-1] ? -bus.b : bus.b;
   assign idle_start_s = (state_q == S_IDLE) && bus.start;
   assign reject_s     = idle_start_s && bus.op && (bus.b == {WIDTH{1'b0}});
   assign accept_s     = idle_start_s && !reject_s;

   // State register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (accept_s) state_d = S_RUN; else state_d = S_IDLE;
         S_RUN:    if (cnt_q == LAST) state_d = S_FINISH; else state_d = S_RUN;
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // One iteration step; acc holds the product upper half or the partial remainder
   always_comb begin
      sum_s    = {1'b0, acc_q} + (quo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
      shf_s    = {acc_q, quo_q[WIDTH-1]};
      dif_s    = shf_s[WIDTH-1:0] - opnd_q;
      acc_nx_s = acc_q;
      quo_nx_s = quo_q;
      if (op_q) begin
         if (shf_s >= {1'b0, opnd_q}) begin
            acc_nx_s = dif_s;
            quo_nx_s = {quo_q[WIDTH-2:0], 1'b1};
         end else begin
            acc_nx_s = shf_s[WIDTH-1:0];
            quo_nx_s = {quo_q[WIDTH-2:0], 1'b0};
         end
      end else begin
         acc_nx_s = sum_s[WIDTH:1];
         quo_nx_s = {sum_s[0], quo_q[WIDTH-1:1]};
      end
   end

   // Output decode; the remainder takes the dividend's sign, quotient/product the XOR of signs
   always_comb begin
      prod_s     = {acc_q, quo_q};
      prod_fix_s = prod_s;
      busy_d     = (state_d == S_RUN);
      done_d     = (state_q == S_FINISH);
      dz_d       = reject_s;
      hi_d       = hi_q;
      lo_d       = lo_q;
      if (state_q == S_FINISH) begin
         if (op_q) begin
            lo_d = neg_q   ? -quo_q : quo_q;
            hi_d = neg_a_q ? -acc_q : acc_q;
         end else begin
            prod_fix_s = neg_q ? -prod_s : prod_s;
            hi_d       = prod_fix_s[2*WIDTH-1:WIDTH];
            lo_d       = prod_fix_s[WIDTH-1:0];
         end
      end else begin
         hi_d = hi_q;
         lo_d = lo_q;
      end
   end

   // Operand latch and iteration datapath
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_q   <= {CW{1'b0}};
         op_q    <= 1'b0;
         neg_q   <= 1'b0;
         neg_a_q <= 1'b0;
         opnd_q  <= {WIDTH{1'b0}};
         acc_q   <= {WIDTH{1'b0}};
         quo_q   <= {WIDTH{1'b0}};
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept_s) begin
                  op_q    <= bus.op;
                  neg_q   <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                  neg_a_q <= bus.a[WIDTH-1];
                  opnd_q  <= bus.op ? mag_b_s : mag_a_s;
                  quo_q   <= bus.op ? mag_a_s : mag_b_s;
                  acc_q   <= {WIDTH{1'b0}};
                  cnt_q   <= {CW{1'b0}};
               end
            end
            S_RUN: begin
               acc_q <= acc_nx_s;
               quo_q <= quo_nx_s;
               cnt_q <= cnt_q + CNT_ONE;
            end
            default: begin
            end
         endcase
      end
   end

   // Registered outputs
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         busy_q <= 1'b0;
         done_q <= 1'b0;
         dz_q   <= 1'b0;
         hi_q   <= {WIDTH{1'b0}};
         lo_q   <= {WIDTH{1'b0}};
      end else begin
         busy_q <= busy_d;
         done_q <= done_d;
         dz_q   <= dz_d;
         hi_q   <= hi_d;
         lo_q   <= lo_d;
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.div_zero = dz_q;
   assign bus.hi       = hi_q;
   assign bus.lo       = lo_q;
   assign bus.hi_write = done_q;
   assign bus.lo_write = done_q;
endmodule
